// File: rtl/idelay_tap_pkg.sv
// Shared encodings and tap limits for the IDELAYE2 tap loader.
package idelay_tap_pkg;

    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_WAIT_RDY = 3'd0,
        ST_IDLE     = 3'd1,
        ST_APPLY    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for asynchronous status levels, clearing to 0 on reset.
module bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/idelay_tap_loader.sv
// Serialises load/inc/dec/read tap requests onto per-lane IDELAYE2 LD/CE strobes
// once IDELAYCTRL reports ready, returning the settled CNTVALUEOUT per request.
module idelay_tap_loader
    import idelay_tap_pkg::*;
#(
    parameter int NUM_LANES     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ctrl_ready,
    output logic                       calib_ready,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [LANE_W-1:0]          req_lane,
    input  logic [1:0]                 req_op,
    input  logic [TAP_W-1:0]           req_tap,
    output logic                       rsp_valid,
    output logic [TAP_W-1:0]           rsp_tap,
    output logic                       rsp_err,
    output logic [NUM_LANES-1:0]       dly_ld,
    output logic [NUM_LANES-1:0]       dly_ce,
    output logic                       dly_inc,
    output logic [TAP_W-1:0]           dly_cntvaluein,
    input  logic [TAP_W*NUM_LANES-1:0] dly_cntvalueout
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Out-of-range lanes read as tap 0 and decode to no strobe.
    function automatic logic [TAP_W-1:0] lane_tap(input logic [LANE_W-1:0] lane,
                                                  input logic [TAP_W*NUM_LANES-1:0] taps);
        logic [TAP_W-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(lane) == i) t = taps[TAP_W*i +: TAP_W];
        end
        return t;
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [NUM_LANES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            oh[i] = (int'(lane) == i);
        end
        return oh;
    endfunction

    logic                 rdy_s;
    logic [TAP_W-1:0]     cur_tap_s;
    logic                 req_err_s;
    op_e                  req_op_s;
    state_e               state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [TAP_W-1:0]     rsp_tap_q, rsp_tap_d;
    logic [NUM_LANES-1:0] ld_q, ld_d;
    logic [NUM_LANES-1:0] ce_q, ce_d;
    logic                 inc_q, inc_d;
    logic [TAP_W-1:0]     cntin_q, cntin_d;

    bit_sync u_rdy_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ctrl_ready),
        .q_o   (rdy_s)
    );

    assign req_op_s  = op_e'(req_op);
    assign cur_tap_s = lane_tap(req_lane, dly_cntvalueout);
    // Saturating moves are refused up front so a tap never wraps.
    assign req_err_s = (int'(req_lane) >= NUM_LANES)
                    || ((req_op_s == OP_INC) && (cur_tap_s == TAP_MAX))
                    || ((req_op_s == OP_DEC) && (cur_tap_s == 5'd0));

    // next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
        rsp_tap_d   = '0;
        ld_d        = '0;
        ce_d        = '0;
        inc_d       = 1'b0;
        cntin_d     = '0;
        case (state_q)
            ST_WAIT_RDY: begin
                if (rdy_s) state_d = ST_IDLE;
                else       state_d = ST_WAIT_RDY;
            end
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    lane_d = req_lane;
                    if (req_err_s) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                        rsp_tap_d = cur_tap_s;
                    end else begin
                        state_d = ST_APPLY;
                        ld_d    = (req_op_s == OP_LOAD) ? lane_onehot(req_lane) : '0;
                        ce_d    = ((req_op_s == OP_INC) || (req_op_s == OP_DEC)) ?
                                  lane_onehot(req_lane) : '0;
                        inc_d   = (req_op_s == OP_INC);
                        cntin_d = (req_op_s == OP_LOAD) ? req_tap : 5'd0;
                    end
                end else if (!rdy_s) begin
                    state_d = ST_WAIT_RDY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                cnt_d = '0;
                if (!rdy_s) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_tap_d = lane_tap(lane_q, dly_cntvalueout);
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!rdy_s) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_tap_d = lane_tap(lane_q, dly_cntvalueout);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    rsp_tap_d = lane_tap(lane_q, dly_cntvalueout);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rdy_s) state_d = ST_IDLE;
                else       state_d = ST_WAIT_RDY;
            end
            default: begin
                state_d = ST_WAIT_RDY;
            end
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE);
    end

    // state, captured request and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_RDY;
            lane_q      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tap_q   <= '0;
            ld_q        <= '0;
            ce_q        <= '0;
            inc_q       <= 1'b0;
            cntin_q     <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tap_q   <= rsp_tap_d;
            ld_q        <= ld_d;
            ce_q        <= ce_d;
            inc_q       <= inc_d;
            cntin_q     <= cntin_d;
        end
    end

    assign calib_ready    = rdy_s;
    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_tap        = rsp_tap_q;
    assign dly_ld         = ld_q;
    assign dly_ce         = ce_q;
    assign dly_inc        = inc_q;
    assign dly_cntvaluein = cntin_q;

endmodule

// File: tb/tb_idelay_tap_loader.sv
// Bench for idelay_tap_loader: emulates the IDELAYE2 tap counters and checks
// responses against a per-lane tap model driven by directed and random requests.
module tb_idelay_tap_loader;

    localparam int NL = 8;
    localparam int S  = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ctrl_ready;
    logic            calib_ready;
    logic            req_valid;
    logic            req_ready;
    logic [LW-1:0]   req_lane;
    logic [1:0]      req_op;
    logic [4:0]      req_tap;
    logic            rsp_valid;
    logic [4:0]      rsp_tap;
    logic            rsp_err;
    logic [NL-1:0]   dly_ld;
    logic [NL-1:0]   dly_ce;
    logic            dly_inc;
    logic [4:0]      dly_cntvaluein;
    logic [5*NL-1:0] dly_cntvalueout;

    logic [4:0] emu [NL];
    logic       emu_clr;
    int         model [NL];
    int         n_total = 0;
    int         n_pass  = 0;

    idelay_tap_loader #(.NUM_LANES(NL), .SETTLE_CYCLES(S), .LANE_W(LW)) dut (
        .clk(clk), .reset(reset), .ctrl_ready(ctrl_ready), .calib_ready(calib_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_lane(req_lane),
        .req_op(req_op), .req_tap(req_tap), .rsp_valid(rsp_valid), .rsp_tap(rsp_tap),
        .rsp_err(rsp_err), .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc),
        .dly_cntvaluein(dly_cntvaluein), .dly_cntvalueout(dly_cntvalueout)
    );

    always #5 clk = ~clk;

    // IDELAYE2 tap counters reacting to the strobes
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (emu_clr)        emu[i] <= 5'd0;
            else if (dly_ld[i]) emu[i] <= dly_cntvaluein;
            else if (dly_ce[i]) emu[i] <= dly_inc ? emu[i] + 5'd1 : emu[i] - 5'd1;
        end
    end

    always_comb begin
        dly_cntvalueout = '0;
        for (int i = 0; i < NL; i++) dly_cntvalueout[5*i +: 5] = emu[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, calib_ready, req_ready, rsp_valid, rsp_err, rsp_tap,
                dly_ld, dly_ce, dly_inc, dly_cntvaluein};
    endfunction

    task automatic resync_check(input string tag);
        step(); chk({tag, "_calib_early"}, calib_ready, 1'b0);
        step(); chk({tag, "_calib_rise"}, calib_ready, 1'b1);
                chk({tag, "_reqrdy_early"}, req_ready, 1'b0);
        step(); chk({tag, "_reqrdy_rise"}, req_ready, 1'b1);
    endtask

    task automatic do_req(input int lane, input int op, input int tap);
        int cur, exp_tap, w, early;
        logic err;
        logic [NL-1:0] oh;
        cur     = (lane < NL) ? model[lane] : 0;
        err     = (lane >= NL) || (op == 1 && cur == 31) || (op == 2 && cur == 0);
        exp_tap = err ? cur : (op == 0) ? tap : (op == 1) ? cur + 1 : (op == 2) ? cur - 1 : cur;
        oh      = (lane < NL) ? (8'd1 << lane) : 8'd0;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin step(); w++; end
        chk("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1; req_lane = LW'(lane); req_op = 2'(op); req_tap = 5'(tap);
        step();
        req_valid = 1'b0; req_lane = 4'($urandom_range(0, 15)); req_tap = 5'($urandom);
        chk("req_ready_busy", req_ready, 1'b0);
        if (err) begin
            chk("err_rsp_valid", rsp_valid, 1'b1);
            chk("err_rsp_err", rsp_err, 1'b1);
            chk("err_rsp_tap", rsp_tap, exp_tap);
            chk("err_no_strobe", {dly_ld, dly_ce}, 16'd0);
            step();
            chk("err_rsp_once", rsp_valid, 1'b0);
            chk("err_ready_back", req_ready, 1'b1);
            chk("err_no_strobe_late", {dly_ld, dly_ce}, 16'd0);
        end else begin
            chk("apply_ld", dly_ld, (op == 0) ? oh : 8'd0);
            chk("apply_ce", dly_ce, (op == 1 || op == 2) ? oh : 8'd0);
            if (op == 0) chk("apply_cntvaluein", dly_cntvaluein, tap);
            else if (op != 3) chk("apply_inc", dly_inc, (op == 1));
            early = int'(rsp_valid);
            step();
            chk("strobe_one_cycle", {dly_ld, dly_ce}, 16'd0);
            repeat (S) begin early += int'(rsp_valid); step(); end
            chk("rsp_not_early", early, 0);
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_err", rsp_err, 1'b0);
            chk("rsp_tap", rsp_tap, exp_tap);
            step();
            chk("rsp_once", rsp_valid, 1'b0);
            chk("ready_back", req_ready, 1'b1);
            model[lane] = exp_tap;
        end
    endtask

    initial begin
        int bad, k, r, tp;
        reset = 1'b1; ctrl_ready = 1'b0; emu_clr = 1'b1;
        req_valid = 1'b0; req_lane = '0; req_op = 2'b00; req_tap = 5'd0;
        for (int i = 0; i < NL; i++) model[i] = 0;
        repeat (3) step();
        chk("reset_outs", all_outs(), 32'd0);
        reset = 1'b0; emu_clr = 1'b0;

        // held off while IDELAYCTRL is not ready, even with a request pending
        req_valid = 1'b1; req_lane = 4'd1; req_op = 2'b11;
        bad = 0;
        repeat (50) begin
            step();
            if (req_ready || rsp_valid || (|dly_ld) || (|dly_ce)) bad++;
        end
        chk("startup_quiet", bad, 0);
        req_valid = 1'b0; ctrl_ready = 1'b1;
        resync_check("startup");

        do_req(3, 0, 17);
        do_req(0, 0, 5);
        do_req(0, 1, 0);
        do_req(0, 2, 0);
        do_req(2, 0, 31);
        do_req(2, 1, 0);
        do_req(0, 0, 0);
        do_req(0, 2, 0);
        do_req(9, 3, 0);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 3);
            tp = (r == 0) ? 0 : (r == 1) ? 31 : $urandom_range(0, 31);
            do_req($urandom_range(0, 9), $urandom_range(0, 3), tp);
        end

        // ready lost while settling a load on lane 1
        req_valid = 1'b1; req_lane = 4'd1; req_op = 2'b00; req_tap = 5'd22;
        step();
        req_valid = 1'b0;
        chk("rl_strobe", dly_ld, 8'h02);
        step();
        ctrl_ready = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 12) begin step(); k++; end
        chk("rl_latency", k, 3);
        chk("rl_rsp_err", rsp_err, 1'b1);
        chk("rl_rsp_tap", rsp_tap, 22);
        model[1] = 22;
        bad = 0;
        repeat (6) begin
            step();
            if (req_ready || rsp_valid || calib_ready) bad++;
        end
        chk("rl_wait_rdy", bad, 0);
        ctrl_ready = 1'b1;
        resync_check("rl");

        // reset asserted mid-SETTLE of an increment
        do_req(3, 0, 10);
        req_valid = 1'b1; req_lane = 4'd3; req_op = 2'b01;
        step();
        req_valid = 1'b0;
        chk("rst_ce_strobe", dly_ce, 8'h08);
        step(); step();
        reset = 1'b1;
        #1;
        chk("rst_async_outs", all_outs(), 32'd0);
        model[3] = 11;
        bad = 0;
        repeat (3) begin
            step();
            if (all_outs() !== 32'd0) bad++;
        end
        chk("rst_held_quiet", bad, 0);
        reset = 1'b0;
        resync_check("rst");
        do_req(3, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
